line_buffer: RTL and testbench

Double-buffered scanline buffer that sits directly upstream of the palette lookup. A pixel producer streams colour indices for the next scanline into one bank over a valid/ready handshake, while the other bank is read out at the VGA timing position and emits one 8-bit colour index per pixel. Banks swap at the end of each active line. The block requests the next line, and flags underrun when a line was not fully delivered in time.

---
 rtl/linebuf_pkg.sv | 12 +
 rtl/linebuf_ram.sv | 23 ++
 rtl/line_buffer.sv | 134 +++++++++++++
 tb/tb_line_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared types and defaults for the double-buffered scanline buffer.
package linebuf_pkg;

  localparam int LINEBUF_IDXW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/linebuf_ram.sv
// Simple dual-port RAM holding both scanline banks; the bank select is the address MSB.
module linebuf_ram
  import linebuf_pkg::*;
#(
  parameter int DW = LINEBUF_IDXW,
  parameter int AW = 11
) (
  input  logic          clk_pix,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_pix) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_buffer.sv
// Double-buffered scanline buffer feeding the palette lookup: one bank is displayed while the other fills.
// Optional horizontal scroll of the read address is enabled by defining LINEBUF_HSCROLL_EN.
module line_buffer
  import linebuf_pkg::*;
#(
  parameter int CORDW = 11,
  parameter int HRES  = 640,
  parameter int VRES  = 480,
  parameter int IDXW  = LINEBUF_IDXW
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
`ifdef LINEBUF_HSCROLL_EN
  input  logic [CORDW-1:0] hscroll,
`endif
  input  logic             de,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDXW-1:0]  wr_data,
  output logic             line_req,
  output logic [CORDW-1:0] line_req_y,
  output logic [IDXW-1:0]  colour,
  output logic             underrun,
  output fill_state_e      fill_state
);

  localparam int AW = $clog2(HRES);
  localparam logic [AW-1:0]    WPTR_LAST = AW'(HRES - 1);
  localparam logic [CORDW-1:0] HRES_C    = CORDW'(HRES);
  localparam logic [CORDW-1:0] VRES_C    = CORDW'(VRES);

  fill_state_e      state, state_next;
  logic [AW-1:0]    wptr;
  logic             rd_bank;
  logic             de_q;
  logic             swap;
  logic             accept;
  logic [CORDW-1:0] sy_plus2;
  logic [CORDW-1:0] req_y_next;
  logic [AW-1:0]    rd_addr;
  logic [IDXW-1:0]  ram_q;

  // Handshake: a beat transfers on a rising clk_pix edge where wr_valid && wr_ready.
  // wr_ready depends only on fill state and the swap condition, never on wr_valid.
  assign swap     = de_q & ~de;
  assign wr_ready = (state == FILL) && !swap;
  assign accept   = wr_valid && wr_ready;
  assign fill_state = state;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FILL;
      FILL:    if (accept && (wptr == WPTR_LAST)) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (swap) state_next = FILL;
  end

  // A swap in FILL means the producer fell behind; the stale tail stays visible.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      de_q     <= 1'b0;
      rd_bank  <= 1'b0;
      wptr     <= '0;
      underrun <= 1'b0;
    end else begin
      de_q <= de;
      if (swap) begin
        rd_bank <= ~rd_bank;
        wptr    <= '0;
        if (state == FILL) underrun <= 1'b1;
      end else if (accept) begin
        wptr <= wptr + 1'b1;
      end
    end
  end

  // The line being filled is two ahead of the line whose display just ended.
  assign sy_plus2   = sy + CORDW'(2);
  assign req_y_next = (sy_plus2 >= VRES_C) ? sy_plus2 - VRES_C : sy_plus2;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      line_req   <= 1'b0;
      line_req_y <= '0;
    end else begin
      line_req <= (state == IDLE) || swap;
      if (state == IDLE)  line_req_y <= CORDW'(1);
      else if (swap)      line_req_y <= req_y_next;
    end
  end

`ifdef LINEBUF_HSCROLL_EN
  logic [CORDW:0] rd_base;
  logic [CORDW:0] rd_sum;
  logic [CORDW:0] rd_wrapped;
  logic           unused_rd_hi;

  assign rd_base      = (sx < HRES_C) ? {1'b0, sx} : '0;
  assign rd_sum       = rd_base + {1'b0, hscroll};
  assign rd_wrapped   = (rd_sum >= {1'b0, HRES_C}) ? rd_sum - {1'b0, HRES_C} : rd_sum;
  assign rd_addr      = rd_wrapped[AW-1:0];
  assign unused_rd_hi = ^rd_wrapped[CORDW:AW];
`else
  assign rd_addr = (sx < HRES_C) ? sx[AW-1:0] : '0;
`endif

  linebuf_ram #(
    .DW (IDXW),
    .AW (AW + 1)
  ) u_ram (
    .clk_pix (clk_pix),
    .wr_en   (accept),
    .wr_addr ({~rd_bank, wptr}),
    .wr_data (wr_data),
    .rd_addr ({rd_bank, rd_addr}),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) colour <= '0;
    else         colour <= ram_q;
  end

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer with a small VGA timing model (16x4 active, 24x6 total).
// Expected colours are queued when sx is presented and compared two cycles later.
`timescale 1ns/1ps
module tb_line_buffer;
  import linebuf_pkg::*;

  localparam int CORDW   = 11;
  localparam int HRES    = 16;
  localparam int VRES    = 4;
  localparam int IDXW    = 8;
  localparam int H_TOTAL = 24;
  localparam int V_TOTAL = 6;
  localparam int START_P = 120;
  localparam int N_CYC   = 212;
`ifdef LINEBUF_HSCROLL_EN
  localparam int HS = 5;
`else
  localparam int HS = 0;
`endif

  logic             clk_pix = 1'b0;
  logic             rst_pix = 1'b1;
  logic [CORDW-1:0] sx, sy;
  logic             de;
  logic             wr_valid;
  logic             wr_ready;
  logic [IDXW-1:0]  wr_data;
  logic             line_req;
  logic [CORDW-1:0] line_req_y;
  logic [IDXW-1:0]  colour;
  logic             underrun;
  fill_state_e      fill_state;
`ifdef LINEBUF_HSCROLL_EN
  logic [CORDW-1:0] hscroll = CORDW'(HS);
`endif

  logic [IDXW-1:0] exp_q[$];
  logic [IDXW-1:0] prod_last;
  logic [IDXW-1:0] ev;
  logic            rdy_prev;
  int              cyc;
  int              n_checks;
  int              n_fail;
  int              vblank_reqs;

  always #5 clk_pix = ~clk_pix;

  line_buffer #(
    .CORDW (CORDW),
    .HRES  (HRES),
    .VRES  (VRES),
    .IDXW  (IDXW)
  ) dut (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .sx         (sx),
    .sy         (sy),
`ifdef LINEBUF_HSCROLL_EN
    .hscroll    (hscroll),
`endif
    .de         (de),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .line_req   (line_req),
    .line_req_y (line_req_y),
    .colour     (colour),
    .underrun   (underrun),
    .fill_state (fill_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_vga(input int c);
    int p;
    p  = c + START_P;
    sx = CORDW'(p % H_TOTAL);
    sy = CORDW'((p / H_TOTAL) % V_TOTAL);
    de = ((p % H_TOTAL) < HRES) && (((p / H_TOTAL) % V_TOTAL) < VRES);
  endtask

  task automatic prod_start(input logic [IDXW-1:0] first, input logic [IDXW-1:0] last);
    wr_valid  = 1'b1;
    wr_data   = first;
    prod_last = last;
  endtask

  // Expected colour for the sx presented in cycle c, for the displayed lines under test.
  function automatic bit exp_colour(input int c, output logic [IDXW-1:0] v);
    int k, a;
    k = (c + START_P) % H_TOTAL;
    a = (k + HS) % HRES;
    exp_colour = 1'b1;
    if (c >= 48 && c <= 63)        v = IDXW'(8'h10 + a);
    else if (c >= 72 && c <= 87)   v = IDXW'(8'h20 + a);
    else if (c >= 96 && c <= 111)  v = (a < 10) ? IDXW'(8'h30 + a) : IDXW'(8'h10 + a);
    else if (c >= 168 && c <= 183) v = IDXW'(8'h40 + a);
    else if (c >= 192 && c <= 207) v = IDXW'(8'h50 + a);
    else begin
      exp_colour = 1'b0;
      v = '0;
    end
  endfunction

  task automatic step();
    @(posedge clk_pix);
    #1;
    cyc++;
    if (wr_valid && rdy_prev) begin
      if (wr_data == prod_last) wr_valid = 1'b0;
      else                      wr_data  = wr_data + 1'b1;
    end
    set_vga(cyc);
    case (cyc)
      1:   prod_start(8'h10, 8'h1F);
      41:  prod_start(8'h20, 8'h2F);
      65:  prod_start(8'h30, 8'h39);
      88:  prod_start(8'h40, 8'h4F);
      113: prod_start(8'h50, 8'h5F);
      default: ;
    endcase
    #1;
    rdy_prev = wr_ready;
  endtask

  task automatic cycle_checks();
    case (cyc)
      0: check_eq("line_req_c0", line_req, 1'b0);
      1: begin
        check_eq("line_req_first", line_req, 1'b1);
        check_eq("line_req_y_first", line_req_y, 1);
        check_eq("wr_ready_first", wr_ready, 1'b1);
        check_eq("state_fill", fill_state, FILL);
      end
      2: begin
        check_eq("line_req_one_cycle", line_req, 1'b0);
        check_eq("line_req_y_hold", line_req_y, 1);
      end
      16: check_eq("wr_ready_last_beat", wr_ready, 1'b1);
      17: begin
        check_eq("wr_ready_done", wr_ready, 1'b0);
        check_eq("state_done", fill_state, DONE);
      end
      41: begin
        check_eq("line_req_swap0", line_req, 1'b1);
        check_eq("line_req_y_swap0", line_req_y, 2);
        check_eq("wr_ready_after_swap", wr_ready, 1'b1);
      end
      60: check_eq("underrun_clear", underrun, 1'b0);
      65: begin
        check_eq("line_req_swap1", line_req, 1'b1);
        check_eq("line_req_y_swap1", line_req_y, 3);
      end
      75: check_eq("state_short_fill", fill_state, FILL);
      88: begin
        check_eq("wr_ready_swap_cycle", wr_ready, 1'b0);
        check_eq("underrun_before_short", underrun, 1'b0);
      end
      89: begin
        check_eq("underrun_set", underrun, 1'b1);
        check_eq("line_req_swap2", line_req, 1'b1);
        check_eq("line_req_y_swap2", line_req_y, 0);
        check_eq("wr_ready_post_swap", wr_ready, 1'b1);
      end
      113: begin
        check_eq("line_req_swap3", line_req, 1'b1);
        check_eq("line_req_y_wrap", line_req_y, 1);
      end
      167: check_eq("line_req_y_vblank", line_req_y, 1);
      168: check_eq("vblank_line_reqs", vblank_reqs, 0);
      185: begin
        check_eq("line_req_frame2", line_req, 1'b1);
        check_eq("line_req_y_frame2", line_req_y, 2);
      end
      210: check_eq("underrun_sticky", underrun, 1'b1);
      default: ;
    endcase
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    vblank_reqs = 0;
    cyc         = -1;
    wr_valid    = 1'b0;
    wr_data     = '0;
    prod_last   = '0;
    rdy_prev    = 1'b0;
    set_vga(0);

    repeat (3) @(posedge clk_pix);
    #1;
    check_eq("rst_colour", colour, 0);
    check_eq("rst_line_req", line_req, 1'b0);
    check_eq("rst_line_req_y", line_req_y, 0);
    check_eq("rst_wr_ready", wr_ready, 1'b0);
    check_eq("rst_underrun", underrun, 1'b0);
    check_eq("rst_state", fill_state, IDLE);

    @(posedge clk_pix);
    #1;
    rst_pix = 1'b0;
    cyc = 0;
    set_vga(0);
    #1;
    rdy_prev = wr_ready;
    cycle_checks();

    while (cyc < N_CYC) begin
      step();
      cycle_checks();
      if (cyc >= 114 && cyc <= 167 && line_req) vblank_reqs++;
      if (exp_colour(cyc, ev)) exp_q.push_back(ev);
      if (exp_colour(cyc - 2, ev)) begin
        if (exp_q.size() == 0) check_eq("colour_queue_empty", 1, 0);
        else                   check_eq("colour", colour, exp_q.pop_front());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
